// File: rtl/seq_pattern_bank.sv
// seq_pattern_bank: a parametrised step-sequencer pattern store.
// It holds NUM_BANKS patterns. Each pattern is NUM_STEPS rows of NUM_CHANNELS
// trigger bits. The block supports:
//   - toggle editing of single rows,
//   - a clear that wipes one bank a row at a time while busy is high,
//   - tick-driven playback with a step counter.
// A bank switch requested during playback waits until the step counter
// wraps to 0, so a pattern always plays through to its end.
module seq_pattern_bank #(
  parameter int NUM_STEPS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_BANKS    = 2,
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        mode,
  input  logic [BW-1:0]                     bank_sel,
  input  logic [SW-1:0]                     edit_step,
  input  logic [NUM_CHANNELS-1:0]           tgl,
  input  logic                              clr_req,
  input  logic                              beat_tick,
  output logic                              busy,
  output logic [SW-1:0]                     play_step,
  output logic [NUM_CHANNELS-1:0]           play_smpl,
  output logic [BW-1:0]                     active_bank,
  output logic [NUM_STEPS*NUM_CHANNELS-1:0] seq_flat
);

  localparam logic [1:0]    MODE_EDIT = 2'd0;
  localparam logic [1:0]    MODE_PLAY = 2'd1;

  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_CLEAR  = 1'b1;

  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

  // Pattern storage, indexed as [bank][step].
  logic [NUM_CHANNELS-1:0] pattern [NUM_BANKS][NUM_STEPS];

  // Clear sequencer state.
  logic [0:0]    state;
  logic [BW-1:0] clr_bank;
  logic [SW-1:0] clr_idx;

  // Playback state.
  logic          play_q;      // mode was PLAY in the previous cycle
  logic          pend_valid;  // a bank switch is waiting for the wrap
  logic [BW-1:0] pend_bank;

  // Decoded controls.
  logic          bank_ok;
  logic          step_ok;
  logic          clr_start;
  logic          edit_en;
  logic          in_play;
  logic          enter_play;
  logic          advance;
  logic          wrap_switch;
  logic [SW-1:0] nxt_step;
  logic [BW-1:0] cur_bank;

  assign busy = (state == ST_CLEAR);

  // Decode which request (if any) is accepted this cycle.
  always_comb begin
    bank_ok   = (int'(bank_sel) < NUM_BANKS);
    step_ok   = (int'(edit_step) < NUM_STEPS);
    clr_start = (state == ST_IDLE) && clr_req && bank_ok;
    // A clear request wins over a toggle issued in the same cycle.
    edit_en   = (state == ST_IDLE) && (mode == MODE_EDIT) && bank_ok && step_ok
                && !clr_req;
  end

  // Work out the next playback step and the bank used for that step.
  always_comb begin
    in_play     = (mode == MODE_PLAY);
    enter_play  = in_play && !play_q;
    advance     = in_play && play_q && beat_tick;
    nxt_step    = (play_step == LAST_STEP) ? '0 : play_step + 1'b1;
    // A pending switch takes effect only when the step counter wraps to 0.
    wrap_switch = advance && (nxt_step == '0) && pend_valid;
    cur_bank    = wrap_switch ? pend_bank : active_bank;
  end

  // Present every row of the selected bank. A bank number that does not
  // exist reads as 0.
  always_comb begin
    // NOTE: assign a default at the top of always_comb so that every path
    // drives seq_flat. Without it, synthesis infers a latch.
    seq_flat = '0;
    if (bank_ok) begin
      for (int s = 0; s < NUM_STEPS; s++) begin
        seq_flat[s*NUM_CHANNELS +: NUM_CHANNELS] = pattern[bank_sel][s];
      end
    end
  end

  // Clear sequencer: wipe one row per cycle, then return to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the values from before the clock edge.
      state    <= ST_IDLE;
      clr_bank <= '0;
      clr_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_bank <= bank_sel;
            clr_idx  <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_idx == LAST_STEP) begin
            state <= ST_IDLE;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pattern store writes: reset wipe, clear-row wipe, or toggle edit.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset on purpose. A pattern must come out of reset
      // silent, so we pay for a reset on each storage bit. This also means
      // the array cannot map onto a RAM macro.
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int s = 0; s < NUM_STEPS; s++) begin
          pattern[b][s] <= '0;
        end
      end
    end else if (state == ST_CLEAR) begin
      pattern[clr_bank][clr_idx] <= '0;
    end else if (edit_en) begin
      pattern[bank_sel][edit_step] <= pattern[bank_sel][edit_step] ^ tgl;
    end
  end

  // Playback: step counter, registered sample row, active and pending bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      play_q      <= 1'b0;
      play_step   <= '0;
      play_smpl   <= '0;
      active_bank <= '0;
      pend_valid  <= 1'b0;
      pend_bank   <= '0;
    end else begin
      play_q <= in_play;
      if (in_play) begin
        if (enter_play) begin
          // Step 0 sounds as soon as playback starts, without waiting for a
          // tick.
          play_step <= '0;
          play_smpl <= pattern[active_bank][0];
        end else if (advance) begin
          play_step   <= nxt_step;
          play_smpl   <= pattern[cur_bank][nxt_step];
          active_bank <= cur_bank;
        end
        // The most recent request wins. If bank_sel moves back to the bank
        // that will play, the pending switch is cancelled.
        if (bank_ok && (bank_sel != cur_bank)) begin
          pend_valid <= 1'b1;
          pend_bank  <= bank_sel;
        end else begin
          pend_valid <= 1'b0;
        end
      end else begin
        play_step  <= '0;
        play_smpl  <= '0;
        pend_valid <= 1'b0;
        if (bank_ok) begin
          active_bank <= bank_sel;
        end
      end
    end
  end

endmodule

// File: doc/seq_pattern_bank.md
Name: seq_pattern_bank

Overview:
- Parametrised step-sequencer pattern store. Successor to the fixed 8-step x 4-sample editor.
- Holds NUM_BANKS patterns of NUM_STEPS x NUM_CHANNELS bits and supports toggle editing of any bank.
- Adds a multi-cycle bank clear with a busy flag, and tick-driven playback with a step counter.
- Bank switches requested during playback are deferred to the next wrap. Sits between the input decode/debounce logic and the sample-trigger/display logic.

Parameters:
NUM_STEPS, 8, steps per pattern (>=2; need not be a power of two)
NUM_CHANNELS, 4, sample channels per step
NUM_BANKS, 2, pattern banks (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mode  in  2  0=edit, 1=play, 2/3=hold (no edit, no playback)
- bank_sel  in  BW  bank addressed for edit, clear, display and play-select; BW=max(1,clog2(NUM_BANKS))
- edit_step  in  SW  step to edit; SW=max(1,clog2(NUM_STEPS))
- tgl  in  NUM_CHANNELS  one-cycle toggle mask for the edited step
- clr_req  in  1  one-cycle request to clear bank bank_sel
- beat_tick  in  1  one-cycle step-advance strobe
- busy  out  1  clear in progress
- play_step  out  SW  current playback step
- play_smpl  out  NUM_CHANNELS  row of the active bank at play_step (registered)
- active_bank  out  BW  bank currently used for playback
- seq_flat  out  NUM_STEPS*NUM_CHANNELS  all rows of bank bank_sel; step 0 in the LSBs (combinational read)

Behaviour:

Reset (synchronous, rst=1 at a clk edge):
- All pattern bits = 0; busy=0; play_step=0; play_smpl=0; active_bank=0; pending switch cleared; FSM -> IDLE.
- Reset mid-clear aborts the clear. The remaining rows are zeroed anyway by the reset itself.

FSM states:
- IDLE -> CLEAR on clr_req=1. Latch clr_bank=bank_sel and clr_idx=0; busy=1 from the next cycle.
- CLEAR: each cycle zero row [clr_bank][clr_idx], then clr_idx++. After the row NUM_STEPS-1 write -> IDLE, busy=0.
- Clear takes exactly NUM_STEPS cycles with busy=1.
- clr_req while busy is ignored (not queued).

Edit:
- Applies when mode=0, FSM=IDLE and edit_step<NUM_STEPS.
- row[bank_sel][edit_step] ^= tgl on the clock edge; the change is visible on seq_flat next cycle.
- tgl is ignored while busy, in modes 1-3, and when edit_step>=NUM_STEPS.
- clr_req and nonzero tgl in the same IDLE cycle: the clear is taken and the toggle is dropped.
- bank_sel >= NUM_BANKS: edits and clears are ignored; seq_flat reads 0.

Playback (mode=1):
- On beat_tick: nxt = (play_step==NUM_STEPS-1) ? 0 : play_step+1.
- play_step<=nxt; play_smpl<=row[bank'][nxt]. bank' is the pending bank if nxt==0 and a switch is pending (active_bank<=bank' in the same cycle), otherwise active_bank.
- Latency: play_smpl valid 1 cycle after beat_tick.
- Entering mode 1 from another mode: play_step=0, and on that first cycle play_smpl<=row[active_bank][0], so step 0 sounds without a tick.
- Leaving mode 1: play_step<=0, play_smpl<=0.

Bank select:
- In mode 1, a bank_sel value differing from active_bank (and < NUM_BANKS) is recorded as pending. The latest value wins; it is applied only at wrap to step 0.
- In modes 0/2/3, active_bank<=bank_sel (if valid) each cycle and pending is cleared.

Simultaneous events and boundaries:
- Playback continues during CLEAR. Rows read mid-clear return their current contents, whether already zeroed or not.
- beat_tick outside mode 1 has no effect.
- NUM_BANKS=1: BW=1, bank_sel must be 0, pending logic never fires.

Test Plan:
1. Reset, mode=0, bank_sel=0, edit_step=2, tgl=4'b0101 for 1 cycle, then again with tgl=4'b0001 -> seq_flat[11:8]=0101 then 0100; all other bits 0.
2. Edit bank 1 step 0 = 1111, then clr_req with bank_sel=1 -> busy=1 for exactly 8 cycles. A tgl and a second clr_req issued during busy are ignored. Bank 1 ends all-zero; bank 0 is unchanged.
3. Bank 0 rows = step k holds k[3:0]; mode=1; 9 beat_ticks -> play_step 1..7,0,1; play_smpl equals row k one cycle after each tick; wrap 7->0 is correct.
4. In mode 1 at play_step=3, set bank_sel=1 (bank 1 = all 1010) -> active_bank stays 0 through step 7. At the tick to step 0: active_bank=1, play_smpl=1010.
5. Same cycle: clr_req=1, tgl=0011, mode=0 -> the clear starts and the toggle is not applied. Assert rst mid-clear (cycle 3) -> next cycle busy=0 and all outputs 0.
6. NUM_STEPS=5, NUM_CHANNELS=3, NUM_BANKS=3: edit_step=6 ignored. Playback wraps 4->0. bank_sel=3 ignored and seq_flat=0.
